// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU writeback stage.
//   - Default data / address widths.
//   - Bit positions of the C-instruction dest and jump fields.
//   - Memory-write handshake FSM state type.
package hack_pkg;

  localparam int unsigned N_DEFAULT    = 16;
  localparam int unsigned PC_W_DEFAULT = 15;

  // dest field {d1, d2, d3}
  localparam int unsigned DEST_A = 2;
  localparam int unsigned DEST_D = 1;
  localparam int unsigned DEST_M = 0;

  // jump field {j1, j2, j3}
  localparam int unsigned J_LT = 2;
  localparam int unsigned J_EQ = 1;
  localparam int unsigned J_GT = 0;

  typedef enum logic {
    StIdle,
    StPend
  } wr_state_e;

endpackage

// File: rtl/hack_jump_cond.sv
// Combinational jump-condition evaluation for a C-instruction.
// Ports:
//   alu_out  - ALU result of the current C-instruction
//   jump     - {lt, eq, gt} jump bits
//   zr_now   - alu_out is zero
//   ng_now   - alu_out is negative (MSB set)
//   taken    - jump condition holds
module hack_jump_cond
  import hack_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic [N-1:0] alu_out,
  input  logic [2:0]   jump,
  output logic         zr_now,
  output logic         ng_now,
  output logic         taken
);

  always_comb begin
    zr_now = (alu_out == '0);
    ng_now = alu_out[N-1];
    taken  = (jump[J_LT] & ng_now) |
             (jump[J_EQ] & zr_now) |
             (jump[J_GT] & ~ng_now & ~zr_now);
  end

endmodule

// File: rtl/hack_writeback.sv
// Hack CPU writeback / sequencing stage.
// Consumes one ALU result per accepted instruction and updates A, D, PC, the
// status flags and a one-deep data-memory write port.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_valid / in_ready   - instruction handshake
//   is_c, inst_imm        - instruction type, A-instruction literal
//   alu_out, dest, jump   - C-instruction result and control fields
//   a_reg, d_reg, pc      - architectural registers
//   m_wdata, m_addr, m_we - pending memory write, held until m_wready
//   zr, ng                - flags of the last C-result
module hack_writeback
  import hack_pkg::*;
#(
  parameter int unsigned N    = N_DEFAULT,
  parameter int unsigned PC_W = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_c,
  input  logic [N-1:0]    inst_imm,
  input  logic [N-1:0]    alu_out,
  input  logic [2:0]      dest,
  input  logic [2:0]      jump,
  output logic [N-1:0]    a_reg,
  output logic [N-1:0]    d_reg,
  output logic [PC_W-1:0] pc,
  output logic [N-1:0]    m_wdata,
  output logic [PC_W-1:0] m_addr,
  output logic            m_we,
  input  logic            m_wready,
  output logic            zr,
  output logic            ng
);

  wr_state_e       state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    d_q, d_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [N-1:0]    wdata_q, wdata_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic            zr_q, zr_d;
  logic            ng_q, ng_d;

  logic zr_now, ng_now, taken, accept;

  hack_jump_cond #(
    .N(N)
  ) u_jump_cond (
    .alu_out(alu_out),
    .jump   (jump),
    .zr_now (zr_now),
    .ng_now (ng_now),
    .taken  (taken)
  );

  assign m_we     = (state_q == StPend);
  assign in_ready = ~reset & (~m_we | m_wready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    d_d     = d_q;
    pc_d    = pc_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    zr_d    = zr_q;
    ng_d    = ng_q;

    // Completion first; a new M-write on the same edge re-arms below.
    if (m_we && m_wready) begin
      state_d = StIdle;
    end

    if (accept) begin
      if (!is_c) begin
        a_d  = inst_imm;
        pc_d = pc_q + PC_W'(1);
      end else begin
        zr_d = zr_now;
        ng_d = ng_now;
        // Jump target and write address both use A as it was before this edge.
        pc_d = taken ? a_q[PC_W-1:0] : pc_q + PC_W'(1);
        if (dest[DEST_A]) a_d = alu_out;
        if (dest[DEST_D]) d_d = alu_out;
        if (dest[DEST_M]) begin
          wdata_d = alu_out;
          addr_d  = a_q[PC_W-1:0];
          state_d = StPend;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      d_q     <= '0;
      pc_q    <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      d_q     <= d_d;
      pc_q    <= pc_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
    end
  end

  assign a_reg   = a_q;
  assign d_reg   = d_q;
  assign pc      = pc_q;
  assign m_wdata = wdata_q;
  assign m_addr  = addr_q;
  assign zr      = zr_q;
  assign ng      = ng_q;

endmodule

// File: tb/tb_hack_writeback.sv
// Self-checking bench for hack_writeback: directed scenarios followed by
// randomized traffic, compared against a cycle-level behavioural model.
module tb_hack_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        is_c;
  logic [15:0] inst_imm;
  logic [15:0] alu_out;
  logic [2:0]  dest;
  logic [2:0]  jump;
  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic [14:0] pc;
  logic [15:0] m_wdata;
  logic [14:0] m_addr;
  logic        m_we;
  logic        m_wready;
  logic        zr;
  logic        ng;

  int n_checks = 0;
  int n_fails  = 0;

  // Behavioural model state (plain integers).
  int ma, md, mpc, mwd, mad;
  int mwe, mzr, mng;

  hack_writeback dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .is_c    (is_c),
    .inst_imm(inst_imm),
    .alu_out (alu_out),
    .dest    (dest),
    .jump    (jump),
    .a_reg   (a_reg),
    .d_reg   (d_reg),
    .pc      (pc),
    .m_wdata (m_wdata),
    .m_addr  (m_addr),
    .m_we    (m_we),
    .m_wready(m_wready),
    .zr      (zr),
    .ng      (ng)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of the stage as described by its operating rules.
  task automatic model_step();
    int ready, z, n, tk, old;
    if (reset) begin
      ma = 0; md = 0; mpc = 0; mwd = 0; mad = 0; mwe = 0; mzr = 0; mng = 0;
      return;
    end
    ready = (mwe == 0 || m_wready) ? 1 : 0;
    if (mwe == 1 && m_wready) mwe = 0;
    if (in_valid && ready == 1) begin
      if (!is_c) begin
        ma  = int'(inst_imm);
        mpc = (mpc + 1) % 32768;
      end else begin
        z   = (alu_out == 0) ? 1 : 0;
        n   = (int'(alu_out) >= 32768) ? 1 : 0;
        tk  = ((jump[2] && n == 1) || (jump[1] && z == 1) ||
               (jump[0] && n == 0 && z == 0)) ? 1 : 0;
        old = ma;
        mzr = z;
        mng = n;
        mpc = (tk == 1) ? old % 32768 : (mpc + 1) % 32768;
        if (dest[2]) ma = int'(alu_out);
        if (dest[1]) md = int'(alu_out);
        if (dest[0]) begin
          mwd = int'(alu_out);
          mad = old % 32768;
          mwe = 1;
        end
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic v, input logic c, input logic [15:0] imm,
                     input logic [15:0] alu, input logic [2:0] dst, input logic [2:0] jmp,
                     input logic wr);
    reset = rst; in_valid = v; is_c = c; inst_imm = imm;
    alu_out = alu; dest = dst; jump = jmp; m_wready = wr;
    #1;
    check("in_ready", 32'(in_ready),
          32'((!rst && (mwe == 0 || wr)) ? 1 : 0));
    @(posedge clk);
    model_step();
    #1;
    check("a_reg",   32'(a_reg),   32'(ma));
    check("d_reg",   32'(d_reg),   32'(md));
    check("pc",      32'(pc),      32'(mpc));
    check("m_wdata", 32'(m_wdata), 32'(mwd));
    check("m_addr",  32'(m_addr),  32'(mad));
    check("m_we",    32'(m_we),    32'(mwe));
    check("zr",      32'(zr),      32'(mzr));
    check("ng",      32'(ng),      32'(mng));
  endtask

  initial begin
    logic [15:0] ra;
    ma = 0; md = 0; mpc = 0; mwd = 0; mad = 0; mwe = 0; mzr = 0; mng = 0;
    #1;
    cyc(1, 0, 0, 0, 0, 3'b000, 3'b000, 0);
    cyc(1, 1, 0, 16'd55, 0, 3'b000, 3'b000, 1);
    // A-instruction
    cyc(0, 1, 0, 16'd100, 0, 3'b000, 3'b000, 1);
    check("dir_pc1", 32'(pc), 32'd1);
    check("dir_a100", 32'(a_reg), 32'd100);
    // C: D,M <= 7, write accepted immediately
    cyc(0, 1, 1, 0, 16'd7, 3'b011, 3'b000, 1);
    check("dir_addr100", 32'(m_addr), 32'd100);
    check("dir_we_on", 32'(m_we), 32'd1);
    cyc(0, 0, 0, 0, 0, 3'b000, 3'b000, 1);
    check("dir_we_off", 32'(m_we), 32'd0);
    // Negative result, jlt taken then jgt not taken
    cyc(0, 1, 0, 16'd40, 0, 3'b000, 3'b000, 1);
    cyc(0, 1, 1, 0, 16'hFFFF, 3'b000, 3'b100, 1);
    check("dir_jlt_pc", 32'(pc), 32'd40);
    cyc(0, 1, 1, 0, 16'hFFFF, 3'b000, 3'b001, 1);
    check("dir_jgt_pc", 32'(pc), 32'd41);
    // Unconditional jump uses A before the A update
    cyc(0, 1, 0, 16'd5, 0, 3'b000, 3'b000, 1);
    cyc(0, 1, 1, 0, 16'd9, 3'b100, 3'b111, 1);
    check("dir_jmp_pc", 32'(pc), 32'd5);
    check("dir_jmp_a", 32'(a_reg), 32'd9);
    // Stall: write pending with m_wready low for 3 cycles
    cyc(0, 1, 0, 16'd200, 0, 3'b000, 3'b000, 1);
    cyc(0, 1, 1, 0, 16'd3, 3'b001, 3'b000, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 16'd11, 0, 3'b000, 3'b000, 0);
    check("dir_stall_pc", 32'(pc), 32'd7);
    cyc(0, 1, 0, 16'd11, 0, 3'b000, 3'b000, 1);
    check("dir_release_a", 32'(a_reg), 32'd11);
    // PC wrap
    cyc(0, 1, 0, 16'h7FFF, 0, 3'b000, 3'b000, 1);
    cyc(0, 1, 1, 0, 16'd0, 3'b000, 3'b111, 1);
    check("dir_pc_max", 32'(pc), 32'h7FFF);
    cyc(0, 1, 0, 16'd1, 0, 3'b000, 3'b000, 1);
    check("dir_pc_wrap", 32'(pc), 32'd0);
    // Reset while a write is pending
    cyc(0, 1, 0, 16'd9, 0, 3'b000, 3'b000, 1);
    cyc(0, 1, 1, 0, 16'd5, 3'b001, 3'b000, 0);
    cyc(1, 1, 0, 16'd9, 0, 3'b000, 3'b000, 0);
    check("dir_rst_we", 32'(m_we), 32'd0);
    check("dir_rst_a", 32'(a_reg), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 16'h0000;
        1:       ra = 16'h8000 | 16'($urandom);
        default: ra = 16'($urandom);
      endcase
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
          16'($urandom), ra, 3'($urandom), 3'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
